alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU of the 32-bit MIPS-style datapath. Consumes the 4-bit ALU control code from the
//  ALU controller plus two operands; produces a registered result and zero flag. AND/OR/ADD/SUB/SLT/NOR
//  take 1 cycle. MUL is a 32-iteration shift-add multiply that stalls upstream through in_ready.
// PARAMETERS
//  DATA_W   32  operand/result width (= `DATA_BITS)
//  CTRL_W    4  control code width (= `ALUCONTROL_BITS)
//  MUL_ITER 32  multiply iterations (= DATA_W); counter width $clog2(MUL_ITER)+1
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operation presented on alu_ctrl/src_a/src_b
//  in_ready   out  1       unit can accept; high only in IDLE
//  alu_ctrl   in   CTRL_W  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL, 1100 NOR
//  src_a      in   DATA_W  operand A (rs)
//  src_b      in   DATA_W  operand B (rt / immediate)
//  out_valid  out  1       1-cycle pulse: result/zero/ovf/illegal valid
//  result     out  DATA_W  registered result, held until next out_valid
//  zero       out  1       result == 0 (branch compare)
//  ovf        out  1       signed overflow, ADD/SUB only, else 0
//  illegal    out  1       alu_ctrl not in the table above
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1 the cycle after reset, out_valid=0, result=0, zero=1, ovf=0, illegal=0,
//    iteration counter=0, partial product=0. Reset mid-MUL aborts it; no out_valid for that op.
//  - Accept: in_valid & in_ready sampled at edge N. in_valid while in_ready=0 is ignored. Upstream must hold
//    the op until accepted.
//  - Single-cycle ops: result/zero/ovf registered at edge N; out_valid high for the one cycle after N.
//    ADD/SUB wrap mod 2^32. ovf = operand signs equal (ADD) or differ (SUB) and result sign differs from A.
//    SLT is signed: result = {31'b0, $signed(a) < $signed(b)}. NOR = ~(a|b).
//  - Illegal code: result=0, zero=1, ovf=0, illegal=1, latency 1. illegal=0 on every legal op.
//  - MUL: FSM IDLE -> MUL_RUN -> IDLE. Edge N: latch multiplicand=a, multiplier=b, acc=0, cnt=0,
//    in_ready->0. Each edge N+1..N+32: if multiplier[0] then acc+=multiplicand. Then multiplicand<<=1,
//    multiplier>>=1, cnt++. At edge N+32 (cnt reaches 31->32): result=acc (low 32 bits; unsigned and signed
//    agree), zero updated, ovf=0, state=IDLE. out_valid and in_ready both high in cycle N+33.
//    Fixed latency 33; no early exit.
//  - Back-to-back: new op accepted in the same cycle out_valid is high; single ops at 1/cycle throughput.
//  - out_valid never high two cycles for one op. result is stable between pulses.
// STRUCTURE
//  - def.v: `DATA_BITS, `ALUCONTROL_BITS, `ALU_AND/`ALU_OR/`ALU_ADD/`ALU_SUB/`ALU_SLT/`ALU_MUL/`ALU_NOR
//    code macros (shared with ALU controller), FSM state encodings.
//  - Sub-module seq_multiplier: start/busy/done, a/b in, 32-bit product out; owns cnt, acc, shift regs.
//  - Top: combinational single-cycle ALU, output registers, IDLE/MUL_RUN FSM, in_ready generation.
// TESTING
//  1. ADD a=7 b=5 -> out_valid at +1, result=12, zero=0; ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//  2. SUB a=5 b=5 -> result=0, zero=1, ovf=0; SLT a=0xFFFFFFFF b=1 -> result=1; SLT a=1 b=-1 -> 0.
//  3. MUL a=0x0000FFFF b=0x00010001 -> in_ready low 32 cycles, out_valid at +33, result=0xFFFFFFFF;
//     MUL a=-3 b=7 -> 0xFFFFFFEB.
//  4. in_valid held with ADD during MUL busy -> ignored until IDLE; then ADD accepted the cycle MUL
//     out_valid fires, and its out_valid follows next cycle.
//  5. rst asserted at MUL iteration 10 -> no out_valid; in_ready=1, result=0 after reset; next ADD correct.
//  6. alu_ctrl=4'b0011 -> result=0, zero=1, illegal=1, latency 1; following AND 0xF0F0&0xFF00 ->
//     0xF000, illegal=0.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, control codes, FSM states and the single-cycle ALU function.
package alu_exec_unit_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned MUL_ITER = DATA_W;
    localparam int unsigned CNT_W    = $clog2(MUL_ITER) + 1;

    // ALU control codes, shared with the ALU controller
    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_MUL = 4'b1000,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              ovf;
        logic              illegal;
    } alu_res_t;

    // Single-cycle operations; MUL is legal but resolved by the sequential multiplier
    function automatic alu_res_t alu_eval(input logic [CTRL_W-1:0] ctrl,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
        alu_res_t          r;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] diff;
        r    = '0;
        sum  = a + b;
        diff = a - b;
        case (ctrl)
            ALU_AND: r.result = a & b;
            ALU_OR:  r.result = a | b;
            ALU_ADD: begin
                r.result = sum;
                r.ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                r.result = diff;
                r.ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SLT: r.result = DATA_W'($signed(a) < $signed(b));
            ALU_NOR: r.result = ~(a | b);
            ALU_MUL: r.result = '0;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bus between decode and the execute-stage ALU.
interface alu_exec_unit_if
    import alu_exec_unit_pkg::*;
    ();

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              out_valid;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              ovf;
    logic              illegal;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b,
        input  in_ready, out_valid, result, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b,
        output in_ready, out_valid, result, zero, ovf, illegal
    );

endinterface

// File: rtl/alu_exec_unit_mul.sv
// Sequential shift-add multiplier: one partial product per cycle, fixed MUL_ITER cycles.
module alu_exec_unit_mul
    import alu_exec_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done_c,
    output logic [DATA_W-1:0] product_c
);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;

    // Accumulator value after the current iteration; final product on the last one
    always_comb begin
        product_c = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_c    = busy && (cnt_q == CNT_W'(MUL_ITER - 1));
    end

    // Operand latch on start, then one shift-add step per cycle while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (busy) begin
            acc_q    <= product_c;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a stalling sequential MUL.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              illegal_q, illegal_d;
    logic              mul_start_c;
    logic              mul_busy;
    logic              mul_done_c;
    logic [DATA_W-1:0] mul_product_c;
    alu_res_t          alu_r;

    alu_exec_unit_mul u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start_c),
        .a         (bus.src_a),
        .b         (bus.src_b),
        .busy      (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    // Next state and next output register values
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        mul_start_c = 1'b0;
        alu_r       = alu_eval(bus.alu_ctrl, bus.src_a, bus.src_b);
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if (bus.alu_ctrl == ALU_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = ST_MUL_RUN;
                        in_ready_d  = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_r.result;
                        zero_d      = (alu_r.result == '0);
                        ovf_d       = alu_r.ovf;
                        illegal_d   = alu_r.illegal;
                    end
                end
            end
            ST_MUL_RUN: begin
                if (mul_done_c) begin
                    state_d     = ST_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b1;
                    result_d    = mul_product_c;
                    zero_d      = (mul_product_c == '0);
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;

endmodule
